// File: rtl/serial_parallel_pkg.sv
// rtl/serial_parallel_pkg.sv - shared state encodings, frame-type codes and default widths
package serial_parallel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TYPE    = 2'd1,
    RECEIVE = 2'd2
  } state_t;

  // Type-bit values, common with the parallel-to-serial transmitter
  localparam logic ADDR_ACK = 1'b0;
  localparam logic DATA_ACK = 1'b1;

  localparam int DEFAULT_PARALLEL_PORT_WIDTH = 15;
  localparam int DEFAULT_BIT_LENGTH          = 4;

endpackage

// File: rtl/serial_parallel.sv
// rtl/serial_parallel.sv - single-wire frame receiver; optional SERIAL_PARALLEL_TYPE_CHECK_EN
// flags frame types whose bit_length disagrees with the type bit.
module serial_parallel
  import serial_parallel_pkg::*;
#(
  parameter int PARALLEL_PORT_WIDTH = DEFAULT_PARALLEL_PORT_WIDTH,
  parameter int BIT_LENGTH          = DEFAULT_BIT_LENGTH
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           din,
  input  logic [BIT_LENGTH-1:0]          bit_length,
  output logic [PARALLEL_PORT_WIDTH-1:0] dout,
  output logic                           dv_out,
  output logic                           frame_type,
  output logic                           busy,
  output logic                           frame_err
);

  localparam int W  = PARALLEL_PORT_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state, state_next;
  logic [CW-1:0] counter, stop;
  logic [W-1:0]  buffer, buf_next;
  logic          cur_type;
  logic          din_bit;
  logic          type_err;
  logic          done;
  int            len;

  // Only a hard 0 is a zero; a floating or unknown line reads as the idle 1
  assign din_bit = (din === 1'b0) ? 1'b0 : 1'b1;
  assign busy    = (state != IDLE);

  always_comb begin
    len      = 0;
    type_err = 1'b0;
    buf_next = buffer | (W'(din_bit) << counter);
    done     = (state == RECEIVE) && (counter == stop);
    if (din_bit == ADDR_ACK) begin
      len = W;
    end else begin
      len = (int'(bit_length) < W) ? int'(bit_length) : W;
    end
`ifdef SERIAL_PARALLEL_TYPE_CHECK_EN
    if (din_bit == ADDR_ACK) begin
      type_err = (int'(bit_length) != W);
    end else begin
      type_err = (int'(bit_length) == W);
    end
`endif
    state_next = state;
    case (state)
      IDLE:    if (din_bit == 1'b0) state_next = TYPE;
      TYPE:    state_next = (type_err || len == 0) ? IDLE : RECEIVE;
      RECEIVE: if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      counter    <= '0;
      stop       <= '0;
      buffer     <= '0;
      cur_type   <= 1'b0;
      dout       <= '0;
      dv_out     <= 1'b0;
      frame_type <= 1'b0;
    end else begin
      state  <= state_next;
      dv_out <= 1'b0;
      case (state)
        IDLE: if (din_bit == 1'b0) buffer <= '0;
        TYPE: begin
          cur_type <= din_bit;
          counter  <= CW'(W - 1);
          stop     <= CW'(W - len);
        end
        RECEIVE: begin
          buffer  <= buf_next;
          counter <= counter - 1'b1;
          if (done) begin
            dout       <= buf_next;
            dv_out     <= 1'b1;
            frame_type <= cur_type;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_PARALLEL_TYPE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= (state == TYPE) && type_err;
  end
  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_parallel.sv
// tb/tb_serial_parallel.sv - self-checking bench for serial_parallel; honours SERIAL_PARALLEL_TYPE_CHECK_EN
module tb_serial_parallel;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rstn;
  logic         din;
  logic [3:0]   bit_length;
  logic [W-1:0] dout;
  logic         dv_out, frame_type, busy, frame_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_dout = '0;
  logic         exp_type = 1'b0;

  serial_parallel dut (
    .clk        (clk),
    .rstn       (rstn),
    .din        (din),
    .bit_length (bit_length),
    .dout       (dout),
    .dv_out     (dv_out),
    .frame_type (frame_type),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: length from the type bit and bit_length, word = payload left-aligned in W bits
  task automatic send_frame(input logic typ, input logic [3:0] bl, input logic [W-1:0] payload,
                            input int gap, output int dv_cnt);
    int len;
    int n;
    bit err;
    logic [W-1:0] word;
    dv_cnt = 0;
    len = (typ == 1'b0) ? W : ((int'(bl) < W) ? int'(bl) : W);
    err = 1'b0;
`ifdef SERIAL_PARALLEL_TYPE_CHECK_EN
    err = (typ == 1'b0) ? (int'(bl) != W) : (int'(bl) == W);
`endif
    if (err) len = 0;
    n = 2 + len;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_length = bl;
      if (i == 0)      din = 1'b0;
      else if (i == 1) din = typ;
      else             din = payload[len - 1 - (i - 2)];
      @(posedge clk);
      #1;
      if (i == n - 1 && len > 0) begin
        word     = payload << (W - len);
        exp_dout = word;
        exp_type = typ;
      end
      if (dv_out) dv_cnt++;
      chk("dv_out",    dv_out,    (i == n - 1 && len > 0));
      chk("busy",      busy,      (i < n - 1));
      chk("frame_err", frame_err, (err && i == 1));
      chk("dout",      dout,      exp_dout);
      chk("frame_type",frame_type,exp_type);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      din = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_dv",   dv_out, 1'b0);
      chk("idle_busy", busy,   1'b0);
      chk("idle_dout", dout,   exp_dout);
    end
  endtask

  typedef struct {
    logic         typ;
    logic [3:0]   bl;
    logic [W-1:0] payload;
    int           gap;
    logic [W-1:0] exp_dout;
    logic         exp_type;
    int           exp_dv;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dv_cnt;
    logic         r_typ;
    logic [3:0]   r_bl;
    logic [W-1:0] r_pay;

    vecs[0] = '{1'b0, 4'd15, 15'h2A5C, 1, 15'h2A5C, 1'b0, 1};
    vecs[1] = '{1'b1, 4'd8,  15'h00B3, 1, 15'h5980, 1'b1, 1};
    vecs[2] = '{1'b1, 4'd0,  15'h0000, 2, 15'h5980, 1'b1, 0};
    vecs[3] = '{1'b1, 4'd8,  15'h00FF, 0, 15'h7F80, 1'b1, 1};
    vecs[4] = '{1'b0, 4'd15, 15'h0001, 1, 15'h0001, 1'b0, 1};
`ifdef SERIAL_PARALLEL_TYPE_CHECK_EN
    vecs[5] = '{1'b0, 4'd8,  15'h1234, 1, 15'h0001, 1'b0, 0};
    vecs[6] = '{1'b1, 4'd15, 15'h7FFF, 1, 15'h0001, 1'b0, 0};
`else
    vecs[5] = '{1'b0, 4'd8,  15'h1234, 1, 15'h1234, 1'b0, 1};
    vecs[6] = '{1'b1, 4'd15, 15'h7FFF, 1, 15'h7FFF, 1'b1, 1};
`endif

    rstn = 1'b0;
    din = 1'b1;
    bit_length = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 15'h0);
    chk("rst_dv", dv_out, 1'b0);
    chk("rst_type", frame_type, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].typ, vecs[k].bl, vecs[k].payload, vecs[k].gap, dv_cnt);
      chk($sformatf("vec%0d_dout", k), dout, vecs[k].exp_dout);
      chk($sformatf("vec%0d_type", k), frame_type, vecs[k].exp_type);
      chk($sformatf("vec%0d_dv", k), dv_cnt, vecs[k].exp_dv);
    end

    // Abort an address frame after 5 payload bits
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bit_length = 4'd15;
      din = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("abort_dv", dv_out, 1'b0);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    exp_dout = '0;
    exp_type = 1'b0;
    chk("abort_dout", dout, 15'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_type", frame_type, 1'b0);
    chk("abort_dv0", dv_out, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    din = 1'b1;
    send_frame(1'b0, 4'd15, 15'h5555, 1, dv_cnt);
    chk("after_abort_dout", dout, 15'h5555);
    chk("after_abort_dv", dv_cnt, 1);

    for (int k = 0; k < 60; k++) begin
      r_typ = 1'($urandom_range(0, 1));
      r_bl  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      r_pay = 15'($urandom);
      send_frame(r_typ, r_bl, r_pay, $urandom_range(0, 2), dv_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
